// File: rtl/vga_timing_gen.sv
// Parameterised VGA sync generator: pixel counters, active-area flag, h/v sync
// and per-pixel/line/frame/vblank strobes, advanced once every CLK_DIV enabled clocks.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 2,
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [X_WIDTH-1:0] counter_x,
    output logic [Y_WIDTH-1:0] counter_y,
    output logic               in_display_area,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic               pixel_strobe,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    // Inclusive upper bounds keep every constant within H_TOTAL-1 / V_TOTAL-1,
    // so they always fit the counter widths.
    localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] X_ACT_HI = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [X_WIDTH-1:0] HS_LO    = X_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [X_WIDTH-1:0] HS_HI    = X_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] Y_ACT_HI = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] VS_LO    = Y_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [Y_WIDTH-1:0] VS_HI    = Y_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic               ACT      = (SYNC_POL != 0);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               de_q, de_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               ps_q, ps_d;
    logic               ls_q, ls_d;
    logic               fs_q, fs_d;
    logic               vbs_q, vbs_d;
    logic               tick, x_wrap, y_wrap;

    always_comb begin
        tick   = en && (div_q == DIV_LAST);
        x_wrap = (x_q == X_LAST);
        y_wrap = (y_q == Y_LAST);

        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;

        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        // Decode is taken from the next counter values so the registered flags
        // line up with counter_x/counter_y on the same edge. Until the first
        // tick after reset the (0,0) pixel keeps in_display_area low.
        if (tick) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + 1'b1;
            end
            de_d = (x_d <= X_ACT_HI) && (y_d <= Y_ACT_HI);
            hs_d = ((x_d >= HS_LO) && (x_d <= HS_HI)) ? ACT : ~ACT;
            vs_d = ((y_d >= VS_LO) && (y_d <= VS_HI)) ? ACT : ~ACT;
        end

        ps_d  = tick;
        ls_d  = tick && x_wrap;
        fs_d  = tick && x_wrap && y_wrap;
        vbs_d = tick && x_wrap && (y_q == Y_ACT_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~ACT;
            vs_q  <= ~ACT;
            ps_q  <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            vbs_q <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ps_q  <= ps_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            vbs_q <= vbs_d;
        end
    end

    assign counter_x       = x_q;
    assign counter_y       = y_q;
    assign in_display_area = de_q;
    assign vga_h_sync      = hs_q;
    assign vga_v_sync      = vs_q;
    assign pixel_strobe    = ps_q;
    assign line_start      = ls_q;
    assign frame_start     = fs_q;
    assign vblank_start    = vbs_q;

endmodule
